instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage of the 20-bit MIPS core: the producer side of the opcode interface that the control unit decodes. Issues word-addressed reads to instruction memory and holds the returned 20-bit instruction in an instruction register (IR) for decode. Absorbs decode back-pressure with a one-entry skid buffer and takes PC redirects for j, taken beq and jmem from execute. Flags opcodes outside the decoded set 0000–1000.

## Interface
- PC_W, 16, PC and instruction-memory address width (word address)
- IW, 20, instruction width; opcode is bits [0:3], MSB first
- RESET_PC, 0, first fetch address after reset

- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- imem_rd  out  1  read strobe; one request per cycle
- imem_addr  out  PC_W  read address, valid when imem_rd=1
- imem_data  in  IW  read data, valid exactly one cycle after the imem_rd cycle
- stall  in  1  decode not ready; hold current instruction
- redirect_valid  in  1  one-cycle pulse; flush and refetch from redirect_pc
- redirect_pc  in  PC_W  new fetch address
- instr_valid  out  1  instr/pc_out hold a live instruction
- instr  out  IW  instruction register
- opcode  out  4  instr[0:3], bit 0 is MSB
- pc_out  out  PC_W  address instr was fetched from
- pc_plus1  out  PC_W  pc_out+1 mod 2^PC_W
- illegal_op  out  1  instr_valid && opcode > 4'b1000

## Operation
- State: fetch_pc, pend_valid/pend_pc (request in flight), IR+ir_pc+instr_valid, skid+skid_pc+skid_valid.
- hold = stall && instr_valid; stall with IR empty has no effect.
- imem_rd = rst_n && !redirect_valid && !hold && !skid_valid; imem_addr = fetch_pc. On issue: fetch_pc <= fetch_pc+1 mod 2^PC_W (0xFFFF -> 0x0000), pend_valid <= 1, pend_pc <= fetch_pc; else pend_valid <= 0.
- Response (pend_valid=1): if IR empty or being consumed (instr_valid && !stall) and skid empty -> IR <= imem_data. If skid full and consumed -> IR <= skid, response goes to skid. If hold -> response to skid (skid never overflows: no issue while skid_valid or hold).
- Consumption edge = instr_valid && !stall. With nothing to load, instr_valid <= 0.
- Skid drains to IR on the first non-hold edge, before any newer response; ordering is strictly program order.
- Redirect (priority over stall and response): at the edge, fetch_pc <= redirect_pc; instr_valid, skid_valid, pend_valid <= 0; in-flight imem_data discarded; imem_rd=0 in the redirect cycle.
- instr/pc_out keep last value when instr_valid=0 (don't-care for consumers).
- illegal_op is combinational from IR; no halt behaviour in this block.

## Timing
- Reset (rst_n=0 at edge): fetch_pc=RESET_PC, instr_valid=0, instr=0, pc_out=0, skid/pend cleared; imem_rd=0 while rst_n=0; illegal_op=0, opcode=0, pc_plus1=1.
- Reset mid-operation: all in-flight and buffered instructions dropped; no response after reset is captured.
- First cycle with rst_n=1 (C0): imem_rd=1, addr=RESET_PC; data at C1; instr_valid=1 from C2.
- Steady state, no stall: one instruction per cycle, latency request->instr_valid = 2 cycles.
- Stall asserted in cycle S with IR valid: instr/pc_out stable while stall=1; imem_rd=0 from S; one in-flight response parked in skid.
- Stall released: skid->IR at that edge, imem_rd resumes next cycle; one bubble after the skid instruction.
- Redirect pulse in cycle R: imem_rd at R+1 with addr=redirect_pc; instr_valid at R+3 with pc_out=redirect_pc. Back-to-back redirects: last one wins.
- Redirect and stall same cycle: redirect wins; stall ignored.

## Test plan
- Reset release, memory word k = {4'b0000, k}: instr_valid at C2, pc_out 0,1,2,3 on consecutive cycles, instr matches, pc_plus1 = pc_out+1.
- Stall 3 cycles while IR holds addr 5: instr/pc_out stay at 5, imem_rd=0, after release pc_out 6 then 7 with no loss or duplicate.
- Redirect to 0x0040 while addr 9 in flight and stall=1: addr 9/10 never appear; imem_addr=0x0040 at R+1; instr_valid with pc_out=0x0040 at R+3.
- RESET_PC=0xFFFE: pc_out sequence 0xFFFE, 0xFFFF, 0x0000; pc_plus1 at 0xFFFF is 0x0000.
- Memory returns opcodes 1000 then 1001 then 1111: illegal_op 0, 1, 1; never asserted when instr_valid=0.
- rst_n low for one cycle mid-stream with skid full: next cycle instr_valid=0, first new fetch addr=RESET_PC.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues word-addressed reads, holds the returned word in the IR,
// absorbs decode back-pressure with a one-entry skid buffer and accepts PC redirects.
module instr_fetch #(
  parameter int unsigned     PC_W     = 16,
  parameter int unsigned     IW       = 20,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_rd,
  output logic [PC_W-1:0] imem_addr,
  input  logic [IW-1:0]   imem_data,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            instr_valid,
  output logic [IW-1:0]   instr,
  output logic [3:0]      opcode,
  output logic [PC_W-1:0] pc_out,
  output logic [PC_W-1:0] pc_plus1,
  output logic            illegal_op
);

  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic            pend_valid_q, pend_valid_d;
  logic [PC_W-1:0] pend_pc_q, pend_pc_d;
  logic [IW-1:0]   ir_q, ir_d;
  logic [PC_W-1:0] ir_pc_q, ir_pc_d;
  logic            ir_valid_q, ir_valid_d;
  logic [IW-1:0]   skid_q, skid_d;
  logic [PC_W-1:0] skid_pc_q, skid_pc_d;
  logic            skid_valid_q, skid_valid_d;

  logic hold;
  logic issue;

  // A stall only matters when there is something in the IR to hold.
  assign hold  = stall && ir_valid_q;
  // No issue while the skid is occupied or held, so the skid can never overflow.
  assign issue = rst_n && !redirect_valid && !hold && !skid_valid_q;

  assign imem_rd   = issue;
  assign imem_addr = fetch_pc_q;

  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    pend_valid_d = pend_valid_q;
    pend_pc_d    = pend_pc_q;
    ir_d         = ir_q;
    ir_pc_d      = ir_pc_q;
    ir_valid_d   = ir_valid_q;
    skid_d       = skid_q;
    skid_pc_d    = skid_pc_q;
    skid_valid_d = skid_valid_q;

    if (redirect_valid) begin
      // Flush everything; the in-flight response is simply not captured.
      fetch_pc_d   = redirect_pc;
      pend_valid_d = 1'b0;
      ir_valid_d   = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      pend_valid_d = issue;
      if (issue) begin
        fetch_pc_d = fetch_pc_q + 1'b1;
        pend_pc_d  = fetch_pc_q;
      end

      if (hold) begin
        if (pend_valid_q) begin
          skid_d       = imem_data;
          skid_pc_d    = pend_pc_q;
          skid_valid_d = 1'b1;
        end
      end else if (skid_valid_q) begin
        // Older skid entry goes first to keep program order.
        ir_d         = skid_q;
        ir_pc_d      = skid_pc_q;
        ir_valid_d   = 1'b1;
        skid_valid_d = pend_valid_q;
        if (pend_valid_q) begin
          skid_d    = imem_data;
          skid_pc_d = pend_pc_q;
        end
      end else if (pend_valid_q) begin
        ir_d       = imem_data;
        ir_pc_d    = pend_pc_q;
        ir_valid_d = 1'b1;
      end else begin
        ir_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_q   <= RESET_PC;
      pend_valid_q <= 1'b0;
      pend_pc_q    <= '0;
      ir_q         <= '0;
      ir_pc_q      <= '0;
      ir_valid_q   <= 1'b0;
      skid_q       <= '0;
      skid_pc_q    <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      pend_valid_q <= pend_valid_d;
      pend_pc_q    <= pend_pc_d;
      ir_q         <= ir_d;
      ir_pc_q      <= ir_pc_d;
      ir_valid_q   <= ir_valid_d;
      skid_q       <= skid_d;
      skid_pc_q    <= skid_pc_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign instr_valid = ir_valid_q;
  assign instr       = ir_q;
  assign opcode      = ir_q[IW-1 -: 4];
  assign pc_out      = ir_pc_q;
  assign pc_plus1    = ir_pc_q + 1'b1;
  assign illegal_op  = ir_valid_q && (opcode > 4'b1000);

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: cycle-exact timing checks, a redirect vector table,
// and an in-order scoreboard of consumed instructions.
module tb_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic        imem_rd;
  logic [15:0] imem_addr;
  logic [19:0] imem_data;
  logic        stall;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        instr_valid;
  logic [19:0] instr;
  logic [3:0]  opcode;
  logic [15:0] pc_out;
  logic [15:0] pc_plus1;
  logic        illegal_op;

  // Second instance with a wrapping reset PC, never stalled or redirected.
  logic        w_rd;
  logic [15:0] w_addr;
  logic [19:0] w_data;
  logic        w_stall;
  logic        w_redir;
  logic [15:0] w_rpc;
  logic        w_valid;
  logic [19:0] w_instr;
  logic [3:0]  w_opcode;
  logic [15:0] w_pc;
  logic [15:0] w_plus1;
  logic        w_ill;

  int checks;
  int failures;
  logic sb_en;
  logic [15:0] exp_q[$];

  instr_fetch #(.PC_W(16), .IW(20), .RESET_PC(16'h0000)) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_rd        (imem_rd),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .opcode         (opcode),
    .pc_out         (pc_out),
    .pc_plus1       (pc_plus1),
    .illegal_op     (illegal_op)
  );

  instr_fetch #(.PC_W(16), .IW(20), .RESET_PC(16'hFFFE)) u_wrap (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_rd        (w_rd),
    .imem_addr      (w_addr),
    .imem_data      (w_data),
    .stall          (w_stall),
    .redirect_valid (w_redir),
    .redirect_pc    (w_rpc),
    .instr_valid    (w_valid),
    .instr          (w_instr),
    .opcode         (w_opcode),
    .pc_out         (w_pc),
    .pc_plus1       (w_plus1),
    .illegal_op     (w_ill)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [19:0] mem_word(input logic [15:0] a);
    case (a)
      16'h0100: return {4'h8, a};
      16'h0101: return {4'h9, a};
      16'h0102: return {4'hF, a};
      default:  return {4'h0, a};
    endcase
  endfunction

  function automatic logic exp_ill(input logic [15:0] a);
    logic [19:0] w;
    w = mem_word(a);
    return w[19:16] > 4'h8;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // Memory models: respond one cycle after each read strobe, junk otherwise.
  initial begin
    logic        rd;
    logic [15:0] a;
    imem_data = 20'hFFFFF;
    forever begin
      @(negedge clk);
      rd = imem_rd;
      a  = imem_addr;
      @(posedge clk);
      #1;
      imem_data = rd ? mem_word(a) : 20'hFFFFF;
    end
  end

  initial begin
    logic        rd;
    logic [15:0] a;
    w_data = 20'hFFFFF;
    forever begin
      @(negedge clk);
      rd = w_rd;
      a  = w_addr;
      @(posedge clk);
      #1;
      w_data = rd ? mem_word(a) : 20'hFFFFF;
    end
  end

  // Scoreboard: every consumed instruction must be the next expected one.
  always @(negedge clk) begin
    if (sb_en && instr_valid && !stall) begin
      if (exp_q.size() == 0) begin
        failures++;
        checks++;
        $display("FAIL sb_extra: got pc %0h expected none", pc_out);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        chk("sb_pc", {16'h0, pc_out}, {16'h0, e});
        chk("sb_instr", {12'h0, instr}, {12'h0, mem_word(e)});
        chk("sb_ill", {31'h0, illegal_op}, {31'h0, exp_ill(e)});
      end
    end
  end

  typedef struct {
    logic [15:0] rpc;
    logic [3:0]  op;
    logic        ill;
    logic [15:0] plus1;
  } vec_t;

  vec_t tbl [5];

  initial begin
    tbl[0] = '{rpc: 16'h0100, op: 4'h8, ill: 1'b0, plus1: 16'h0101};
    tbl[1] = '{rpc: 16'h0101, op: 4'h9, ill: 1'b1, plus1: 16'h0102};
    tbl[2] = '{rpc: 16'h0040, op: 4'h0, ill: 1'b0, plus1: 16'h0041};
    tbl[3] = '{rpc: 16'h0102, op: 4'hF, ill: 1'b1, plus1: 16'h0103};
    tbl[4] = '{rpc: 16'hFFFF, op: 4'h0, ill: 1'b0, plus1: 16'h0000};

    checks = 0;
    failures = 0;
    sb_en = 1'b0;
    rst_n = 1'b0;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    w_stall = 1'b0;
    w_redir = 1'b0;
    w_rpc = '0;

    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_rd", {31'h0, imem_rd}, 32'h0);
    chk("rst_valid", {31'h0, instr_valid}, 32'h0);
    chk("rst_instr", {12'h0, instr}, 32'h0);
    chk("rst_pc", {16'h0, pc_out}, 32'h0);
    chk("rst_plus1", {16'h0, pc_plus1}, 32'h1);
    chk("rst_op", {28'h0, opcode}, 32'h0);
    chk("rst_ill", {31'h0, illegal_op}, 32'h0);

    // C0: reset released
    next_cyc();
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) exp_q.push_back(16'(k));
    sb_en = 1'b1;
    @(negedge clk);
    chk("c0_rd", {31'h0, imem_rd}, 32'h1);
    chk("c0_addr", {16'h0, imem_addr}, 32'h0);
    chk("c0_valid", {31'h0, instr_valid}, 32'h0);
    chk("w_c0_addr", {16'h0, w_addr}, 32'hFFFE);
    next_cyc();
    @(negedge clk);
    chk("c1_valid", {31'h0, instr_valid}, 32'h0);
    chk("c1_addr", {16'h0, imem_addr}, 32'h1);
    for (int k = 0; k < 4; k++) begin
      next_cyc();
      @(negedge clk);
      chk("run_valid", {31'h0, instr_valid}, 32'h1);
      chk("run_pc", {16'h0, pc_out}, k);
      chk("run_plus1", {16'h0, pc_plus1}, k + 1);
    end
    chk("w_valid", {31'h0, w_valid}, 32'h1);
    chk("w_pc_last", {16'h0, w_pc}, 32'h0001);

    // C6, then stall C7..C9 with addr 5 in the IR
    next_cyc();
    for (int k = 0; k < 3; k++) begin
      next_cyc();
      stall = 1'b1;
      @(negedge clk);
      chk("stall_valid", {31'h0, instr_valid}, 32'h1);
      chk("stall_pc", {16'h0, pc_out}, 32'h5);
      chk("stall_rd", {31'h0, imem_rd}, 32'h0);
    end
    next_cyc();
    stall = 1'b0;
    @(negedge clk);
    chk("rel_pc", {16'h0, pc_out}, 32'h5);
    chk("rel_rd", {31'h0, imem_rd}, 32'h0);
    next_cyc();
    @(negedge clk);
    chk("skid_pc", {16'h0, pc_out}, 32'h6);
    chk("resume_rd", {31'h0, imem_rd}, 32'h1);
    chk("resume_addr", {16'h0, imem_addr}, 32'h7);
    next_cyc();
    @(negedge clk);
    chk("bubble", {31'h0, instr_valid}, 32'h0);
    next_cyc();
    @(negedge clk);
    chk("after_bubble_pc", {16'h0, pc_out}, 32'h7);

    // Redirect with stall while addr 9 in flight
    next_cyc();
    redirect_valid = 1'b1;
    redirect_pc = 16'h0040;
    stall = 1'b1;
    for (int k = 0; k < 4; k++) exp_q.push_back(16'h0040 + 16'(k));
    @(negedge clk);
    chk("redir_rd", {31'h0, imem_rd}, 32'h0);
    chk("redir_hold_pc", {16'h0, pc_out}, 32'h8);
    next_cyc();
    redirect_valid = 1'b0;
    stall = 1'b0;
    @(negedge clk);
    chk("redir_r1_addr", {15'h0, imem_rd, imem_addr}, 32'h10040);
    chk("redir_r1_valid", {31'h0, instr_valid}, 32'h0);
    next_cyc();
    @(negedge clk);
    chk("redir_r2_valid", {31'h0, instr_valid}, 32'h0);
    next_cyc();
    @(negedge clk);
    chk("redir_r3", {15'h0, instr_valid, pc_out}, 32'h10040);
    repeat (3) next_cyc();

    // Fill the skid, then reset for one cycle
    next_cyc();
    stall = 1'b1;
    chk("sb_drained1", exp_q.size(), 32'h0);
    next_cyc();
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_rd", {31'h0, imem_rd}, 32'h0);
    next_cyc();
    rst_n = 1'b1;
    stall = 1'b0;
    for (int k = 0; k < 3; k++) exp_q.push_back(16'(k));
    @(negedge clk);
    chk("post_rst_valid", {31'h0, instr_valid}, 32'h0);
    chk("post_rst_fetch", {15'h0, imem_rd, imem_addr}, 32'h10000);
    next_cyc();
    @(negedge clk);
    chk("post_rst_valid2", {31'h0, instr_valid}, 32'h0);
    repeat (3) next_cyc();
    next_cyc();
    sb_en = 1'b0;
    chk("sb_drained2", exp_q.size(), 32'h0);

    // Table: redirect with stall held, then inspect the held instruction
    for (int i = 0; i < 5; i++) begin
      redirect_valid = 1'b1;
      redirect_pc = tbl[i].rpc;
      stall = 1'b1;
      @(negedge clk);
      chk("tbl_r0_rd", {31'h0, imem_rd}, 32'h0);
      next_cyc();
      redirect_valid = 1'b0;
      @(negedge clk);
      chk("tbl_r1_fetch", {15'h0, imem_rd, imem_addr}, {15'h0, 1'b1, tbl[i].rpc});
      chk("tbl_r1_ill", {31'h0, illegal_op}, 32'h0);
      next_cyc();
      @(negedge clk);
      chk("tbl_r2_fetch", {15'h0, imem_rd, imem_addr}, {15'h0, 1'b1, 16'(tbl[i].rpc + 16'h1)});
      chk("tbl_r2_valid", {31'h0, instr_valid}, 32'h0);
      chk("tbl_r2_ill", {31'h0, illegal_op}, 32'h0);
      next_cyc();
      @(negedge clk);
      chk("tbl_pc", {15'h0, instr_valid, pc_out}, {15'h0, 1'b1, tbl[i].rpc});
      chk("tbl_instr", {12'h0, instr}, {12'h0, mem_word(tbl[i].rpc)});
      chk("tbl_op", {28'h0, opcode}, {28'h0, tbl[i].op});
      chk("tbl_ill", {31'h0, illegal_op}, {31'h0, tbl[i].ill});
      chk("tbl_plus1", {16'h0, pc_plus1}, {16'h0, tbl[i].plus1});
      chk("tbl_hold_rd", {31'h0, imem_rd}, 32'h0);
      next_cyc();
    end

    // Consecutive opcodes 1000, 1001, 1111 without stall
    redirect_valid = 1'b1;
    redirect_pc = 16'h0100;
    stall = 1'b0;
    next_cyc();
    redirect_valid = 1'b0;
    for (int k = 0; k < 3; k++) exp_q.push_back(16'h0100 + 16'(k));
    sb_en = 1'b1;
    repeat (2) next_cyc();
    @(negedge clk);
    chk("seq_ill0", {31'h0, illegal_op}, 32'h0);
    next_cyc();
    @(negedge clk);
    chk("seq_ill1", {31'h0, illegal_op}, 32'h1);
    next_cyc();
    @(negedge clk);
    chk("seq_ill2", {31'h0, illegal_op}, 32'h1);
    next_cyc();
    sb_en = 1'b0;
    chk("sb_drained3", exp_q.size(), 32'h0);

    // Back-to-back redirects: the last one wins
    redirect_valid = 1'b1;
    redirect_pc = 16'h0200;
    @(negedge clk);
    chk("b2b_r0_rd", {31'h0, imem_rd}, 32'h0);
    next_cyc();
    redirect_pc = 16'h0300;
    @(negedge clk);
    chk("b2b_r1_rd", {31'h0, imem_rd}, 32'h0);
    next_cyc();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("b2b_fetch", {15'h0, imem_rd, imem_addr}, 32'h10300);
    next_cyc();
    @(negedge clk);
    chk("b2b_gap", {31'h0, instr_valid}, 32'h0);
    next_cyc();
    @(negedge clk);
    chk("b2b_pc", {15'h0, instr_valid, pc_out}, 32'h10300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
